// File: rtl/cv_ctrl_ports_if.sv
// Controller-port bundle between the joystick muxing / console side and the
// cv_ctrl_ports engine: key and spinner inputs, select strobes, pin outputs.
interface cv_ctrl_ports_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int DELTA_W     = 8
);
  logic [20*NUM_PLAYERS-1:0]      keys_i;
  logic [NUM_PLAYERS-1:0]         sel_kp_n_i;
  logic [NUM_PLAYERS-1:0]         sel_js_n_i;
  logic [DELTA_W*NUM_PLAYERS-1:0] spin_delta_i;
  logic [NUM_PLAYERS-1:0]         spin_stb_i;
  logic [4*NUM_PLAYERS-1:0]       ctrl_o;
  logic [NUM_PLAYERS-1:0]         p6_o;
  logic [NUM_PLAYERS-1:0]         p7_o;
  logic [NUM_PLAYERS-1:0]         p9_o;

  modport master (
    output keys_i, sel_kp_n_i, sel_js_n_i, spin_delta_i, spin_stb_i,
    input  ctrl_o, p6_o, p7_o, p9_o
  );

  modport slave (
    input  keys_i, sel_kp_n_i, sel_js_n_i, spin_delta_i, spin_stb_i,
    output ctrl_o, p6_o, p7_o, p9_o
  );
endinterface

// File: rtl/cv_ctrl_ports.sv
// ColecoVision controller-port engine: keypad/joystick nibble encoding on
// p1-p4/p6 and spinner quadrature on p7/p9, all pins registered.
module cv_ctrl_ports #(
  parameter int NUM_PLAYERS = 2,
  parameter int DELTA_W     = 8,
  parameter int ACC_W       = 10,
  parameter int SPIN_DIV    = 2048
) (
  input logic           clk,
  input logic           reset,
  cv_ctrl_ports_if.slave bus
);

  localparam int TW        = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam int SW        = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 2;
  localparam int ACC_MAX_I = (2 ** (ACC_W - 1)) - 1;

  localparam logic [TW-1:0]        TIMER_LAST = TW'(SPIN_DIV - 1);
  localparam logic [TW-1:0]        TIMER_ONE  = TW'(1);
  localparam logic signed [SW-1:0] S_ONE      = SW'(1);
  localparam logic signed [SW-1:0] ACC_MAX    = SW'(ACC_MAX_I);
  localparam logic signed [SW-1:0] ACC_MIN    = SW'(-ACC_MAX_I);

  function automatic logic [3:0] code_lut(input logic [3:0] idx);
    logic [3:0] c;
    case (idx)
      4'd0:    c = 4'b0011;
      4'd1:    c = 4'b1110;
      4'd2:    c = 4'b1101;
      4'd3:    c = 4'b0110;
      4'd4:    c = 4'b0001;
      4'd5:    c = 4'b1001;
      4'd6:    c = 4'b0111;
      4'd7:    c = 4'b1100;
      4'd8:    c = 4'b1000;
      4'd9:    c = 4'b1011;
      4'd10:   c = 4'b1010;
      4'd11:   c = 4'b0101;
      4'd12:   c = 4'b0100;
      4'd13:   c = 4'b0010;
      default: c = 4'b1111;
    endcase
    return c;
  endfunction

  // Scan from the top so the lowest set key index overwrites last and wins.
  function automatic logic [3:0] kp_code(input logic [13:0] k);
    logic [3:0] c;
    c = 4'b1111;
    for (int i = 13; i >= 0; i--) begin
      c = k[i] ? code_lut(4'(i)) : c;
    end
    return c;
  endfunction

  // {p7,p9} follows a Gray sequence so only one line moves per step.
  function automatic logic [1:0] quad_map(input logic [1:0] phase);
    logic [1:0] q;
    case (phase)
      2'd0:    q = 2'b11;
      2'd1:    q = 2'b01;
      2'd2:    q = 2'b00;
      2'd3:    q = 2'b10;
      default: q = 2'b11;
    endcase
    return q;
  endfunction

  logic [TW-1:0] timer_r;
  logic          tick_s;

  assign tick_s = (timer_r == TIMER_LAST);

  // Shared free-running step timer; tick marks the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= {TW{1'b0}};
    end else if (tick_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_port
    logic [19:0]               keys_s;
    logic signed [DELTA_W-1:0] delta_s;
    logic [3:0]                kp_nib_s;
    logic [3:0]                js_nib_s;
    logic                      kp_p6_s;
    logic                      js_p6_s;
    logic signed [SW-1:0]      sum_s;
    logic                      step_up_s;
    logic                      step_dn_s;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic [1:0]                phase_r;
    logic [1:0]                phase_next_s;
    logic [3:0]                ctrl_r;
    logic                      p6_r;
    logic [1:0]                quad_r;

    assign keys_s  = bus.keys_i[20*p +: 20];
    assign delta_s = bus.spin_delta_i[DELTA_W*p +: DELTA_W];

    // Select-gated keypad and joystick terms; the pins wire-AND both sources.
    always_comb begin
      kp_nib_s = 4'b1111;
      kp_p6_s  = 1'b1;
      js_nib_s = 4'b1111;
      js_p6_s  = 1'b1;
      if (!bus.sel_kp_n_i[p]) begin
        kp_nib_s = kp_code(keys_s[13:0]);
        kp_p6_s  = ~keys_s[19];
      end else begin
        kp_nib_s = 4'b1111;
        kp_p6_s  = 1'b1;
      end
      if (!bus.sel_js_n_i[p]) begin
        js_nib_s = ~{keys_s[14], keys_s[15], keys_s[16], keys_s[17]};
        js_p6_s  = ~keys_s[18];
      end else begin
        js_nib_s = 4'b1111;
        js_p6_s  = 1'b1;
      end
    end

    // Accumulator drains one count per tick toward zero while strobes add motion.
    always_comb begin
      step_up_s    = tick_s & ~acc_r[ACC_W-1] & (acc_r != {ACC_W{1'b0}});
      step_dn_s    = tick_s & acc_r[ACC_W-1];
      sum_s        = SW'(acc_r);
      acc_next_s   = acc_r;
      phase_next_s = phase_r;
      if (bus.spin_stb_i[p]) begin
        sum_s = sum_s + SW'(delta_s);
      end else begin
        sum_s = sum_s;
      end
      if (step_up_s) begin
        sum_s        = sum_s - S_ONE;
        phase_next_s = phase_r + 2'd1;
      end else if (step_dn_s) begin
        sum_s        = sum_s + S_ONE;
        phase_next_s = phase_r - 2'd1;
      end else begin
        phase_next_s = phase_r;
      end
      if (sum_s > ACC_MAX) begin
        acc_next_s = ACC_MAX[ACC_W-1:0];
      end else if (sum_s < ACC_MIN) begin
        acc_next_s = ACC_MIN[ACC_W-1:0];
      end else begin
        acc_next_s = sum_s[ACC_W-1:0];
      end
    end

    // Port state and pin registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        acc_r   <= {ACC_W{1'b0}};
        phase_r <= 2'd0;
        ctrl_r  <= 4'b1111;
        p6_r    <= 1'b1;
        quad_r  <= 2'b11;
      end else begin
        acc_r   <= acc_next_s;
        phase_r <= phase_next_s;
        ctrl_r  <= kp_nib_s & js_nib_s;
        p6_r    <= kp_p6_s & js_p6_s;
        quad_r  <= quad_map(phase_next_s);
      end
    end

    assign bus.ctrl_o[4*p +: 4] = ctrl_r;
    assign bus.p6_o[p]          = p6_r;
    assign bus.p7_o[p]          = quad_r[1];
    assign bus.p9_o[p]          = quad_r[0];
  end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Directed bench for cv_ctrl_ports (2 ports, ACC_W=4, SPIN_DIV=4).
module tb_cv_ctrl_ports;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cv_ctrl_ports_if #(.NUM_PLAYERS(2), .DELTA_W(8)) bus ();

  cv_ctrl_ports #(
    .NUM_PLAYERS(2),
    .DELTA_W    (8),
    .ACC_W      (4),
    .SPIN_DIV   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with reset low; the next posedge is edge 1.
  task automatic apply_reset();
    reset            = 1'b1;
    bus.spin_stb_i   = 2'b00;
    bus.spin_delta_i = 16'h0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.keys_i       = 40'h0;
    bus.sel_kp_n_i   = 2'b11;
    bus.sel_js_n_i   = 2'b11;
    bus.spin_delta_i = 16'h0000;
    bus.spin_stb_i   = 2'b00;
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      checks++;
      if ({bus.ctrl_o, bus.p6_o, bus.p7_o, bus.p9_o} !== 14'h3FFF) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h want 3fff", c,
                 {bus.ctrl_o, bus.p6_o, bus.p7_o, bus.p9_o});
      end
    end
  endtask

  task automatic test_keypad();
    logic [19:0] kv [10];
    logic [3:0]  ev [10];
    logic        ep6[10];
    kv[0] = 20'h00220; ev[0] = 4'b1001; ep6[0] = 1'b1;
    kv[1] = 20'h80220; ev[1] = 4'b1001; ep6[1] = 1'b0;
    kv[2] = 20'h02001; ev[2] = 4'b0011; ep6[2] = 1'b1;
    kv[3] = 20'h01000; ev[3] = 4'b0100; ep6[3] = 1'b1;
    kv[4] = 20'h01800; ev[4] = 4'b0101; ep6[4] = 1'b1;
    kv[5] = 20'h02000; ev[5] = 4'b0010; ep6[5] = 1'b1;
    kv[6] = 20'h00400; ev[6] = 4'b1010; ep6[6] = 1'b1;
    kv[7] = 20'h00090; ev[7] = 4'b0001; ep6[7] = 1'b1;
    kv[8] = 20'h00100; ev[8] = 4'b1000; ep6[8] = 1'b1;
    kv[9] = 20'h00000; ev[9] = 4'b1111; ep6[9] = 1'b1;
    bus.sel_kp_n_i = 2'b10;
    bus.sel_js_n_i = 2'b11;
    for (int i = 0; i < 10; i++) begin
      bus.keys_i = {20'h0, kv[i]};
      if (i == 0) begin
        #1;
        checks++;
        if (bus.ctrl_o[3:0] !== 4'b1111) begin
          errors++;
          $display("FAIL kp_latency: got %b want 1111", bus.ctrl_o[3:0]);
        end
      end
      step();
      checks++;
      if (bus.ctrl_o !== {4'b1111, ev[i]}) begin
        errors++;
        $display("FAIL kp_nibble vec %0d: got %b want %b", i, bus.ctrl_o, {4'b1111, ev[i]});
      end
      checks++;
      if (bus.p6_o !== {1'b1, ep6[i]}) begin
        errors++;
        $display("FAIL kp_p6 vec %0d: got %b want %b", i, bus.p6_o, {1'b1, ep6[i]});
      end
    end
  endtask

  task automatic test_joystick();
    logic [19:0] kv [5];
    logic [1:0]  skp[5];
    logic [1:0]  sjs[5];
    logic [3:0]  ev [5];
    logic        ep6[5];
    kv[0] = 20'h64000; skp[0] = 2'b11; sjs[0] = 2'b01; ev[0] = 4'b0110; ep6[0] = 1'b0;
    kv[1] = 20'h04000; skp[1] = 2'b11; sjs[1] = 2'b01; ev[1] = 4'b0111; ep6[1] = 1'b1;
    kv[2] = 20'h18000; skp[2] = 2'b11; sjs[2] = 2'b01; ev[2] = 4'b1001; ep6[2] = 1'b1;
    kv[3] = 20'h64400; skp[3] = 2'b01; sjs[3] = 2'b01; ev[3] = 4'b0010; ep6[3] = 1'b0;
    kv[4] = 20'h90002; skp[4] = 2'b01; sjs[4] = 2'b01; ev[4] = 4'b1100; ep6[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.keys_i     = {kv[i], 20'h0};
      bus.sel_kp_n_i = skp[i];
      bus.sel_js_n_i = sjs[i];
      step();
      checks++;
      if (bus.ctrl_o !== {ev[i], 4'b1111}) begin
        errors++;
        $display("FAIL js_nibble vec %0d: got %b want %b", i, bus.ctrl_o, {ev[i], 4'b1111});
      end
      checks++;
      if (bus.p6_o !== {ep6[i], 1'b1}) begin
        errors++;
        $display("FAIL js_p6 vec %0d: got %b want %b", i, bus.p6_o, {ep6[i], 1'b1});
      end
    end
    bus.sel_kp_n_i = 2'b11;
    bus.sel_js_n_i = 2'b11;
    step();
    checks++;
    if ({bus.ctrl_o, bus.p6_o} !== 10'h3FF) begin
      errors++;
      $display("FAIL js_deselect: got %h want 3ff", {bus.ctrl_o, bus.p6_o});
    end
    bus.keys_i = 40'h0;
  endtask

  task automatic test_spin_forward();
    logic [1:0] qv [4];
    int ph0;
    int ph1;
    qv[0] = 2'b11; qv[1] = 2'b01; qv[2] = 2'b00; qv[3] = 2'b10;
    apply_reset();
    bus.spin_delta_i = {8'hFE, 8'h03};
    bus.spin_stb_i   = 2'b11;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 1) bus.spin_stb_i = 2'b00;
      ph0 = (e / 4 > 3) ? 3 : e / 4;
      ph1 = (e < 4) ? 0 : ((e < 8) ? 3 : 2);
      checks++;
      if ({bus.p7_o[0], bus.p9_o[0]} !== qv[ph0]) begin
        errors++;
        $display("FAIL spin_fwd_p0 edge %0d: got %b want %b", e, {bus.p7_o[0], bus.p9_o[0]}, qv[ph0]);
      end
      checks++;
      if ({bus.p7_o[1], bus.p9_o[1]} !== qv[ph1]) begin
        errors++;
        $display("FAIL spin_rev_p1 edge %0d: got %b want %b", e, {bus.p7_o[1], bus.p9_o[1]}, qv[ph1]);
      end
    end
  endtask

  task automatic test_spin_reverse();
    logic [1:0] qv [4];
    int ph;
    qv[0] = 2'b11; qv[1] = 2'b01; qv[2] = 2'b00; qv[3] = 2'b10;
    apply_reset();
    bus.spin_delta_i = {8'h00, 8'hFE};
    bus.spin_stb_i   = 2'b01;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 1) bus.spin_stb_i = 2'b00;
      ph = (e < 4) ? 0 : ((e < 8) ? 3 : 2);
      checks++;
      if ({bus.p7_o[0], bus.p9_o[0]} !== qv[ph]) begin
        errors++;
        $display("FAIL spin_rev edge %0d: got %b want %b", e, {bus.p7_o[0], bus.p9_o[0]}, qv[ph]);
      end
    end
  endtask

  // acc=-1 with a +1 strobe on the tick edge: step back, acc becomes +1, then one step forward.
  task automatic test_strobe_on_tick();
    logic [1:0] exp_q;
    apply_reset();
    bus.spin_delta_i = {8'h00, 8'hFF};
    bus.spin_stb_i   = 2'b01;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 1) bus.spin_stb_i = 2'b00;
      if (e == 3) begin
        bus.spin_delta_i = {8'h00, 8'h01};
        bus.spin_stb_i   = 2'b01;
      end
      if (e == 4) bus.spin_stb_i = 2'b00;
      exp_q = (e < 4) ? 2'b11 : ((e < 8) ? 2'b10 : 2'b11);
      checks++;
      if ({bus.p7_o[0], bus.p9_o[0]} !== exp_q) begin
        errors++;
        $display("FAIL stb_tick edge %0d: got %b want %b", e, {bus.p7_o[0], bus.p9_o[0]}, exp_q);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] qv [4];
    int steps;
    qv[0] = 2'b11; qv[1] = 2'b01; qv[2] = 2'b00; qv[3] = 2'b10;
    apply_reset();
    bus.spin_delta_i = {8'h00, 8'h7F};
    bus.spin_stb_i   = 2'b01;
    for (int e = 1; e <= 36; e++) begin
      step();
      if (e == 3) bus.spin_stb_i = 2'b00;
      steps = (e / 4 > 7) ? 7 : e / 4;
      checks++;
      if ({bus.p7_o[0], bus.p9_o[0]} !== qv[steps % 4]) begin
        errors++;
        $display("FAIL sat edge %0d: got %b want %b", e, {bus.p7_o[0], bus.p9_o[0]}, qv[steps % 4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.spin_delta_i = {8'h00, 8'h7F};
    bus.spin_stb_i   = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 3) bus.spin_stb_i = 2'b00;
    end
    checks++;
    if ({bus.p7_o[0], bus.p9_o[0]} !== 2'b00) begin
      errors++;
      $display("FAIL mid_pre: got %b want 00", {bus.p7_o[0], bus.p9_o[0]});
    end
    reset            = 1'b1;
    bus.spin_delta_i = {8'h00, 8'h05};
    bus.spin_stb_i   = 2'b01;
    step();
    checks++;
    if ({bus.p7_o, bus.p9_o, bus.ctrl_o} !== 12'hFFF) begin
      errors++;
      $display("FAIL mid_reset: got %h want fff", {bus.p7_o, bus.p9_o, bus.ctrl_o});
    end
    reset          = 1'b0;
    bus.spin_stb_i = 2'b00;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({bus.p7_o[0], bus.p9_o[0]} !== 2'b11) begin
        errors++;
        $display("FAIL mid_after cycle %0d: got %b want 11", c, {bus.p7_o[0], bus.p9_o[0]});
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_keypad();
    test_joystick();
    test_spin_forward();
    test_spin_reverse();
    test_strobe_on_tick();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
